display_arbiter: RTL and testbench

//  Sequences what the 4-digit 7-segment display controller shows. Arbitrates between a

---
 rtl/display_pkg.sv | 33 +++
 rtl/tick_gen.sv | 32 +++
 rtl/display_arbiter.sv | 169 ++++++++++++++++
 tb/tb_display_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types for the display arbiter: FSM state codes, message record and
// helpers for packing four BCD-style digits into one 16-bit word.
package display_pkg;

  localparam int DIGIT_W  = 4;
  localparam int N_DIGITS = 4;
  localparam int WORD_W   = DIGIT_W * N_DIGITS;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [WORD_W-1:0]  word_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_SHOW_LIVE = 2'd1;
  localparam state_t ST_SHOW_MSG  = 2'd2;
  localparam state_t ST_GAP       = 2'd3;

  typedef struct packed {
    word_t datos;
    logic  blink;
  } msg_t;

  // Digit 1 sits in the least significant nibble.
  function automatic digit_t digit_get(input word_t w, input int idx);
    return w[idx*DIGIT_W +: DIGIT_W];
  endfunction

  function automatic word_t digit_pack(input digit_t d4, input digit_t d3,
                                       input digit_t d2, input digit_t d1);
    return {d4, d3, d2, d1};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks;
// a synchronous restart realigns the tick to the cycle of the restart.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic o_tick
);

  localparam int                CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Tick is purely a function of the count so the restart it triggers cannot loop back.
  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/display_arbiter.sv
// Chooses what the 4-digit display shows: the live value, a held (optionally
// blinking) message, or blank; one message may wait in a pending slot.
module display_arbiter
  import display_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int HOLD_TICKS  = 500,
  parameter int BLINK_TICKS = 125
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Req0_En,
  input  logic [15:0] i_Req0_Datos,
  input  logic        i_Req1_Valid,
  input  logic [15:0] i_Req1_Datos,
  input  logic        i_Req1_Blink,
  output logic        o_Req1_Ready,
  output logic [3:0]  o_Datos1,
  output logic [3:0]  o_Datos2,
  output logic [3:0]  o_Datos3,
  output logic [3:0]  o_Datos4,
  output logic        o_Blank
);

  localparam int                  HOLD_W     = $clog2(HOLD_TICKS + 1);
  localparam int                  BLINK_W    = $clog2(BLINK_TICKS + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  state_t               state_q, state_d;
  msg_t                 active_q, active_d;
  msg_t                 pend_q, pend_d;
  logic                 pend_full_q, pend_full_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  word_t                datos_q, datos_d;
  logic                 blank_q, blank_d;
  logic                 rst_done_q;
  logic                 tick, tick_restart, enter_msg, accept;
  msg_t                 req1_msg;

  assign req1_msg     = '{datos: i_Req1_Datos, blink: i_Req1_Blink};
  assign o_Req1_Ready = ~pend_full_q & rst_done_q;
  assign accept       = i_Req1_Valid & o_Req1_Ready;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (i_Clk),
    .rst_n   (i_Rst),
    .restart (tick_restart),
    .o_tick  (tick)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    hold_d       = hold_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    datos_d      = datos_q;
    blank_d      = blank_q;
    tick_restart = 1'b0;
    enter_msg    = 1'b0;

    case (state_q)
      ST_IDLE, ST_SHOW_LIVE: begin
        if (accept) begin
          active_d  = req1_msg;
          state_d   = ST_SHOW_MSG;
          enter_msg = 1'b1;
        end else begin
          state_d = i_Req0_En ? ST_SHOW_LIVE : ST_IDLE;
        end
      end
      ST_SHOW_MSG: begin
        if (accept) begin
          pend_d      = req1_msg;
          pend_full_d = 1'b1;
        end
        if (tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
          end
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            // A message accepted on this very edge still forces the gap.
            if (pend_full_d) begin
              state_d      = ST_GAP;
              tick_restart = 1'b1;
            end else begin
              state_d = i_Req0_En ? ST_SHOW_LIVE : ST_IDLE;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          active_d    = pend_q;
          pend_full_d = 1'b0;
          state_d     = ST_SHOW_MSG;
          enter_msg   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_msg) begin
      tick_restart = 1'b1;
      hold_d       = '0;
      blink_cnt_d  = '0;
      phase_d      = 1'b0;
    end

    // Outputs are registered from the next state so they change on the same edge.
    case (state_d)
      ST_SHOW_LIVE: begin
        datos_d = i_Req0_Datos;
        blank_d = 1'b0;
      end
      ST_SHOW_MSG: begin
        datos_d = active_d.datos;
        blank_d = active_d.blink & phase_d;
      end
      default: blank_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q     <= ST_IDLE;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      datos_q     <= '0;
      blank_q     <= 1'b1;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      datos_q     <= datos_d;
      blank_q     <= blank_d;
      rst_done_q  <= 1'b1;
    end
  end

  assign o_Datos1 = digit_get(datos_q, 0);
  assign o_Datos2 = digit_get(datos_q, 1);
  assign o_Datos3 = digit_get(datos_q, 2);
  assign o_Datos4 = digit_get(datos_q, 3);
  assign o_Blank  = blank_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed scenarios plus a random
// run checked against a cycle-count model of the arbitration rules.
module tb_display_arbiter;

  localparam int TDIV      = 4;
  localparam int HOLD      = 3;
  localparam int BLINK     = 1;
  localparam int HOLD_CYC  = HOLD * TDIV;
  localparam int BLINK_CYC = BLINK * TDIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] r0 = '0;
  logic        valid = 1'b0;
  logic [15:0] r1 = '0;
  logic        blink = 1'b0;
  logic        ready;
  logic [3:0]  d1, d2, d3, d4;
  logic        blank;
  logic [15:0] dout;

  int total = 0;
  int bad   = 0;

  assign dout = {d4, d3, d2, d1};

  always #5 clk = ~clk;

  display_arbiter #(.TICK_DIV(TDIV), .HOLD_TICKS(HOLD), .BLINK_TICKS(BLINK)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst_n),
    .i_Req0_En    (en),
    .i_Req0_Datos (r0),
    .i_Req1_Valid (valid),
    .i_Req1_Datos (r1),
    .i_Req1_Blink (blink),
    .o_Req1_Ready (ready),
    .o_Datos1     (d1),
    .o_Datos2     (d2),
    .o_Datos3     (d3),
    .o_Datos4     (d4),
    .o_Blank      (blank)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL reset_blank: got %b want 1", blank); end
    total++; if (dout !== 16'h0) begin bad++; $display("FAIL reset_datos: got %h want 0000", dout); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    rst_n = 1'b1;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b want 0", ready); end
    step();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_after_release: got %b want 1", ready); end
    // Async assertion while showing live data
    en = 1'b1; r0 = 16'h1234;
    step();
    total++; if (blank !== 1'b0) begin bad++; $display("FAIL live_before_reset: got %b want 0", blank); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL async_blank: got %b want 1", blank); end
    total++; if (dout !== 16'h0) begin bad++; $display("FAIL async_datos: got %h want 0000", dout); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL async_ready: got %b want 0", ready); end
    step();
    rst_n = 1'b1;
    step();
    valid = 1'b1; r1 = 16'hEEEE; blink = 1'b0;
    step();
    valid = 1'b0;
    step();
    total++; if (dout !== 16'hEEEE) begin bad++; $display("FAIL msg_before_reset: got %h want eeee", dout); end
    // Reset mid-message: the message must not come back
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step();
    step();
    total++; if (dout !== 16'h1234 || blank !== 1'b0) begin
      bad++; $display("FAIL msg_discarded: got %h blank %b want 1234 blank 0", dout, blank);
    end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_after_discard: got %b want 1", ready); end
  endtask

  task automatic test_live();
    en = 1'b0;
    step();
    r0 = 16'h1234; en = 1'b1;
    #1;
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL live_latency: got %b want 1", blank); end
    step();
    total++; if ({d4, d3, d2, d1} !== {4'd1, 4'd2, 4'd3, 4'd4} || blank !== 1'b0) begin
      bad++; $display("FAIL live_digits: got %h blank %b want 1234 blank 0", dout, blank);
    end
    r0 = 16'h5678;
    step();
    total++; if (dout !== 16'h5678) begin bad++; $display("FAIL live_track: got %h want 5678", dout); end
    en = 1'b0;
    step();
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL live_off: got %b want 1", blank); end
  endtask

  task automatic test_msg_over_live();
    en = 1'b1; r0 = 16'h1234;
    step();
    valid = 1'b1; r1 = 16'hABCD; blink = 1'b0;
    step();
    valid = 1'b0;
    for (int i = 0; i < HOLD_CYC; i++) begin
      total++; if (dout !== 16'hABCD || blank !== 1'b0) begin
        bad++; $display("FAIL msg_show[%0d]: got %h blank %b want abcd blank 0", i, dout, blank);
      end
      step();
    end
    total++; if (dout !== 16'h1234 || blank !== 1'b0) begin
      bad++; $display("FAIL msg_return: got %h blank %b want 1234 blank 0", dout, blank);
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; r0 = 16'h1234;
    valid = 1'b1; r1 = 16'h5A5A; blink = 1'b0;
    step();
    for (int i = 0; i < HOLD_CYC; i++) begin
      total++; if (dout !== 16'h5A5A || blank !== 1'b0) begin
        bad++; $display("FAIL b2b_first[%0d]: got %h blank %b want 5a5a blank 0", i, dout, blank);
      end
      total++; if (ready !== (i == 0)) begin
        bad++; $display("FAIL b2b_ready_first[%0d]: got %b want %b", i, ready, i == 0);
      end
      valid = (i == 0);
      r1    = 16'hC3C3;
      step();
    end
    valid = 1'b0;
    for (int i = 0; i < TDIV; i++) begin
      total++; if (blank !== 1'b1 || ready !== 1'b0) begin
        bad++; $display("FAIL b2b_gap[%0d]: got blank %b ready %b want blank 1 ready 0", i, blank, ready);
      end
      step();
    end
    for (int i = 0; i < HOLD_CYC; i++) begin
      total++; if (dout !== 16'hC3C3 || blank !== 1'b0 || ready !== 1'b1) begin
        bad++; $display("FAIL b2b_second[%0d]: got %h blank %b ready %b want c3c3 0 1", i, dout, blank, ready);
      end
      step();
    end
    total++; if (dout !== 16'h1234 || blank !== 1'b0) begin
      bad++; $display("FAIL b2b_return: got %h blank %b want 1234 blank 0", dout, blank);
    end
  endtask

  task automatic test_exit_collision();
    en = 1'b0;
    step();
    valid = 1'b1; r1 = 16'h0F0F; blink = 1'b0;
    step();
    valid = 1'b0;
    for (int i = 0; i < HOLD_CYC; i++) begin
      total++; if (dout !== 16'h0F0F || blank !== 1'b0) begin
        bad++; $display("FAIL col_first[%0d]: got %h blank %b want 0f0f blank 0", i, dout, blank);
      end
      if (i == HOLD_CYC - 1) begin
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL col_ready: got %b want 1", ready); end
        valid = 1'b1; r1 = 16'h7E57;
      end
      step();
    end
    valid = 1'b0;
    for (int i = 0; i < TDIV; i++) begin
      total++; if (blank !== 1'b1) begin bad++; $display("FAIL col_gap[%0d]: got %b want 1", i, blank); end
      step();
    end
    for (int i = 0; i < HOLD_CYC; i++) begin
      total++; if (dout !== 16'h7E57 || blank !== 1'b0) begin
        bad++; $display("FAIL col_second[%0d]: got %h blank %b want 7e57 blank 0", i, dout, blank);
      end
      step();
    end
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL col_idle: got %b want 1", blank); end
  endtask

  task automatic test_blink();
    en = 1'b0;
    valid = 1'b1; r1 = 16'h9876; blink = 1'b1;
    step();
    valid = 1'b0; blink = 1'b0;
    for (int i = 0; i < HOLD_CYC; i++) begin
      total++; if (blank !== ((i / BLINK_CYC) % 2 == 1) || dout !== 16'h9876) begin
        bad++; $display("FAIL blink[%0d]: got %h blank %b want 9876 blank %b",
                        i, dout, blank, (i / BLINK_CYC) % 2 == 1);
      end
      step();
    end
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL blink_idle: got %b want 1", blank); end
  endtask

  // Reference model: what is on screen and for how many cycles, plus a FIFO of waiting messages.
  task automatic test_random();
    int          m_mode;  // 0 idle, 1 live, 2 message, 3 gap
    int          m_el;
    logic [15:0] m_live;
    logic [16:0] m_act;
    logic [16:0] m_q[$];
    bit          m_rdy;
    logic        exp_rdy, acc, exp_blank;

    valid = 1'b0; en = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_mode = 0; m_el = 0; m_live = '0; m_act = '0; m_rdy = 1'b0;
    m_q.delete();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      r0    = 16'($urandom);
      valid = ($urandom_range(0, 3) == 0);
      r1    = 16'($urandom);
      blink = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = m_rdy && (m_q.size() == 0);
      total++; if (ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, ready, exp_rdy); end
      acc = valid && exp_rdy;
      case (m_mode)
        0, 1: begin
          if (acc) begin
            m_act = {r1, blink}; m_mode = 2; m_el = 0;
          end else begin
            m_mode = en ? 1 : 0; m_live = r0;
          end
        end
        2: begin
          if (acc) m_q.push_back({r1, blink});
          m_el++;
          if (m_el == HOLD_CYC) begin
            m_el = 0;
            if (m_q.size() != 0) m_mode = 3;
            else begin
              m_mode = en ? 1 : 0; m_live = r0;
            end
          end
        end
        default: begin
          m_el++;
          if (m_el == TDIV) begin
            m_act = m_q.pop_front(); m_mode = 2; m_el = 0;
          end
        end
      endcase
      m_rdy = 1'b1;
      step();
      exp_blank = (m_mode == 0 || m_mode == 3) ||
                  (m_mode == 2 && m_act[0] && ((m_el / BLINK_CYC) % 2 == 1));
      total++; if (blank !== exp_blank) begin bad++; $display("FAIL rnd_blank[%0d]: got %b want %b", c, blank, exp_blank); end
      if (m_mode == 1) begin
        total++; if (dout !== m_live) begin bad++; $display("FAIL rnd_live[%0d]: got %h want %h", c, dout, m_live); end
      end else if (m_mode == 2) begin
        total++; if (dout !== m_act[16:1]) begin bad++; $display("FAIL rnd_msg[%0d]: got %h want %h", c, dout, m_act[16:1]); end
      end
    end
    valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_live();
    test_msg_over_live();
    test_back_to_back();
    test_exit_collision();
    test_blink();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
